bit_pixel_rotator_ring: RTL and testbench

- Parametrised successor to the two-buffer bit-pixel rotator. Takes bit-packed pixel words (NUM_PIX pixels plus 8 sideband bits) from the DDR3 reader, buffers them in an internal show-ahead FIFO, and writes them into an N-deep ring of BRAM frame buffers, each split into thirds.
- Adds a selectable transpose/raster address mode, SOF/third-index resynchronisation, and overflow detection.
- Sits between the DDR3 reader and the block-matcher BRAMs; it gives way to the block-matching FSM through the bm_idle / bm_working_buf handshake.

---
 rtl/bit_pixel_rotator_ring.sv | 177 +++++++++++++++++
 tb/tb_bit_pixel_rotator_ring.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_pixel_rotator_ring.sv
// Bit-pixel rotator ring: show-ahead FIFO feeding an N-deep ring of BRAM frame
// buffers split into thirds, with transpose/raster walk, resync and overflow.
module bit_pixel_rotator_ring #(
    parameter int THIRD_COLS   = 240,
    parameter int THIRD_ROWS   = 480,
    parameter int NUM_PIX      = 16,
    parameter int NUM_BUFS     = 2,
    parameter int FIFO_DEPTH   = 512,
    parameter int AFULL_THRESH = 32,
    parameter int TRANSPOSE    = 1,
    parameter int LAST_THIRD   = 2,
    localparam int WR_COLS     = THIRD_COLS / NUM_PIX,
    localparam int WA_W        = (WR_COLS * THIRD_ROWS > 1) ? $clog2(WR_COLS * THIRD_ROWS) : 1,
    localparam int BUF_W       = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_PIX+7:0]        bit_pix,
    input  logic                      bit_pix_valid,
    output logic                      fifo_almost_full,
    output logic [NUM_PIX-1:0]        pix_out,
    output logic                      pix_out_wren,
    output logic [BUF_W+2+WA_W-1:0]   pix_out_addr,
    output logic [3:0]                image_number,
    input  logic                      bm_idle,
    input  logic [BUF_W-1:0]          bm_working_buf,
    output logic                      sync_error,
    output logic                      overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int COL_W = (WR_COLS > 1) ? $clog2(WR_COLS) : 1;
    localparam int ROW_W = (THIRD_ROWS > 1) ? $clog2(THIRD_ROWS) : 1;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(WR_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(THIRD_ROWS - 1);
    localparam logic [WA_W-1:0]  ADDR_LAST = WA_W'(WR_COLS * THIRD_ROWS - 1);
    localparam logic [1:0]       LAST_T    = 2'(LAST_THIRD);

    typedef enum logic [0:0] {ST_IDLE, ST_STALL} state_t;

    state_t state, state_n;

    logic [NUM_PIX+7:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]     rd_ptr, wr_ptr, used, used_next;
    logic               empty, full, push;
    logic [NUM_PIX+7:0] head;
    logic [1:0]         head_third;
    logic               head_sof;
    logic               unused_fields;

    logic [BUF_W-1:0]   buf_index, next_buf;
    logic [COL_W-1:0]   col, eff_col, col_n;
    logic [ROW_W-1:0]   row, eff_row, row_n;
    logic [WA_W-1:0]    wr_addr, eff_addr, addr_n;
    logic [1:0]         lat_third;
    logic               resync, third_done, can_adv, adv;

    // ---------------- show-ahead FIFO ----------------
    assign used       = wr_ptr - rd_ptr;
    assign empty      = (used == '0);
    assign full       = (used == (PTR_W+1)'(FIFO_DEPTH));
    assign push       = bit_pix_valid && (!full || pix_out_wren);
    assign used_next  = used + (PTR_W+1)'(push) - (PTR_W+1)'(pix_out_wren);
    assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];
    assign head_third = head[NUM_PIX+3:NUM_PIX+2];
    assign head_sof   = head[NUM_PIX+1];
    assign unused_fields = ^{head[NUM_PIX+7:NUM_PIX+4], head[NUM_PIX]};

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= bit_pix;
    end

    // A resync restarts the walk at offset 0 and the advance proceeds from there.
    assign resync   = (wr_addr != '0) && (head_sof || (head_third != lat_third));
    assign eff_col  = resync ? '0 : col;
    assign eff_row  = resync ? '0 : row;
    assign eff_addr = resync ? '0 : wr_addr;

    always_comb begin
        col_n      = eff_col;
        row_n      = eff_row;
        addr_n     = eff_addr;
        third_done = 1'b0;
        if (TRANSPOSE != 0) begin
            if (eff_row == ROW_LAST) begin
                row_n = '0;
                if (eff_col == COL_LAST) begin
                    col_n      = '0;
                    addr_n     = '0;
                    third_done = 1'b1;
                end else begin
                    col_n  = eff_col + COL_W'(1);
                    addr_n = WA_W'(eff_col) + WA_W'(1);
                end
            end else begin
                row_n  = eff_row + ROW_W'(1);
                addr_n = eff_addr + WA_W'(WR_COLS);
            end
        end else begin
            if (eff_addr == ADDR_LAST) begin
                addr_n     = '0;
                third_done = 1'b1;
            end else begin
                addr_n = eff_addr + WA_W'(1);
            end
        end
    end

    assign next_buf = (buf_index == BUF_W'(NUM_BUFS - 1)) ? '0 : buf_index + BUF_W'(1);
    assign can_adv  = bm_idle || (bm_working_buf != next_buf);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n      = state;
        adv          = 1'b0;
        pix_out_wren = 1'b0;
        case (state)
            ST_IDLE: begin
                pix_out_wren = !empty;
                if (!empty && third_done && (head_third == LAST_T)) begin
                    if (can_adv) adv = 1'b1;
                    else         state_n = ST_STALL;
                end
            end
            ST_STALL: begin
                if (can_adv) begin
                    adv     = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign pix_out      = pix_out_wren ? head[NUM_PIX-1:0] : '0;
    assign pix_out_addr = pix_out_wren ? {buf_index, head_third, eff_addr} : '0;

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            buf_index        <= '0;
            col              <= '0;
            row              <= '0;
            wr_addr          <= '0;
            lat_third        <= '0;
            image_number     <= '0;
            sync_error       <= 1'b0;
            overflow         <= 1'b0;
            fifo_almost_full <= 1'b0;
        end else begin
            if (push)         wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pix_out_wren) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            fifo_almost_full <= (int'(used_next) > AFULL_THRESH);
            sync_error       <= pix_out_wren && resync;
            if (bit_pix_valid && !push) overflow <= 1'b1;
            if (pix_out_wren) begin
                col     <= col_n;
                row     <= row_n;
                wr_addr <= addr_n;
                if (eff_addr == '0) lat_third <= head_third;
            end
            if (adv) begin
                buf_index    <= next_buf;
                image_number <= image_number + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_bit_pixel_rotator_ring.sv
// Randomised bench for bit_pixel_rotator_ring: a transpose/2-buffer/8-deep
// instance and a raster/3-buffer instance, both against a queue-based model.
module tb_bit_pixel_rotator_ring;
    localparam int NP   = 16;
    localparam int WRC  = 2;
    localparam int ROWS = 4;
    localparam int SIZE = WRC * ROWS;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NP+7:0] bp   [2];
    logic          vld  [2];
    logic          idle [2];
    logic [1:0]    wb   [2];

    logic          afull_a, wren_a, sync_a, ovf_a, afull_b, wren_b, sync_b, ovf_b;
    logic [NP-1:0] pix_a, pix_b;
    logic [5:0]    addr_a;
    logic [6:0]    addr_b;
    logic [3:0]    img_a, img_b;

    bit_pixel_rotator_ring #(
        .THIRD_COLS(32), .THIRD_ROWS(4), .NUM_PIX(16), .NUM_BUFS(2),
        .FIFO_DEPTH(8), .AFULL_THRESH(4), .TRANSPOSE(1), .LAST_THIRD(2)
    ) dut_a (
        .clk(clk), .reset_n(rst_n), .bit_pix(bp[0]), .bit_pix_valid(vld[0]),
        .fifo_almost_full(afull_a), .pix_out(pix_a), .pix_out_wren(wren_a),
        .pix_out_addr(addr_a), .image_number(img_a), .bm_idle(idle[0]),
        .bm_working_buf(wb[0][0:0]), .sync_error(sync_a), .overflow(ovf_a)
    );

    bit_pixel_rotator_ring #(
        .THIRD_COLS(32), .THIRD_ROWS(4), .NUM_PIX(16), .NUM_BUFS(3),
        .FIFO_DEPTH(16), .AFULL_THRESH(8), .TRANSPOSE(0), .LAST_THIRD(2)
    ) dut_b (
        .clk(clk), .reset_n(rst_n), .bit_pix(bp[1]), .bit_pix_valid(vld[1]),
        .fifo_almost_full(afull_b), .pix_out(pix_b), .pix_out_wren(wren_b),
        .pix_out_addr(addr_b), .image_number(img_b), .bm_idle(idle[1]),
        .bm_working_buf(wb[1]), .sync_error(sync_b), .overflow(ovf_b)
    );

    int cfg_tr    [2] = '{1, 0};
    int cfg_nb    [2] = '{2, 3};
    int cfg_depth [2] = '{8, 16};
    int cfg_thr   [2] = '{4, 8};

    // Reference model: FIFO contents as a ring array, walk position as a linear index.
    logic [NP+7:0] mq [2][16];
    int mhd [2], mcnt [2], mpos [2], mlat [2], mstall [2];
    int mbuf [2], mimg [2], movf [2], msync [2];
    int gk [2], gt [2];
    int errors, checks;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int offs(input int i, input int k);
        if (cfg_tr[i] != 0) return (k % ROWS) * WRC + k / ROWS;
        return k;
    endfunction

    function automatic bit can_adv(input int i);
        return idle[i] || (int'(wb[i]) != (mbuf[i] + 1) % cfg_nb[i]);
    endfunction

    task automatic advance(input int i);
        mbuf[i] = (mbuf[i] + 1) % cfg_nb[i];
        mimg[i] = (mimg[i] + 1) % 16;
    endtask

    task automatic check_inst(input int i);
        logic [NP+7:0] w;
        logic [31:0]   ep, ea;
        logic          wr, sy, ov, af;
        logic [NP-1:0] px;
        logic [7:0]    ad;
        logic [3:0]    im;
        int            k;
        bit            pop, rs;
        string         n;
        n = (i == 0) ? "A" : "B";
        if (i == 0) begin
            wr = wren_a; sy = sync_a; ov = ovf_a; af = afull_a; px = pix_a; ad = 8'(addr_a); im = img_a;
        end else begin
            wr = wren_b; sy = sync_b; ov = ovf_b; af = afull_b; px = pix_b; ad = 8'(addr_b); im = img_b;
        end
        pop = (mstall[i] == 0) && (mcnt[i] > 0);
        ep = '0;
        ea = '0;
        if (pop) begin
            w  = mq[i][mhd[i]];
            k  = mpos[i];
            rs = (k != 0) && (w[NP+1] || int'(w[NP+3:NP+2]) != mlat[i]);
            if (rs) k = 0;
            ep = 32'(w[NP-1:0]);
            ea = 32'(mbuf[i] * 32 + int'(w[NP+3:NP+2]) * 8 + offs(i, k));
        end
        check_val({n, ".wren"},  32'(wr), 32'(pop));
        check_val({n, ".pix"},   32'(px), ep);
        check_val({n, ".addr"},  32'(ad), ea);
        check_val({n, ".image"}, 32'(im), 32'(mimg[i]));
        check_val({n, ".ovf"},   32'(ov), 32'(movf[i]));
        check_val({n, ".sync"},  32'(sy), 32'(msync[i]));
        check_val({n, ".afull"}, 32'(af), 32'(mcnt[i] > cfg_thr[i]));
    endtask

    task automatic model_edge(input int i);
        logic [NP+7:0] w;
        int k, th;
        bit rs;
        if (!rst_n) begin
            mhd[i] = 0; mcnt[i] = 0; mpos[i] = 0; mlat[i] = 0; mstall[i] = 0;
            mbuf[i] = 0; mimg[i] = 0; movf[i] = 0; msync[i] = 0;
            return;
        end
        msync[i] = 0;
        if (mstall[i] != 0) begin
            if (can_adv(i)) begin
                advance(i);
                mstall[i] = 0;
            end
        end else if (mcnt[i] > 0) begin
            w  = mq[i][mhd[i]];
            th = int'(w[NP+3:NP+2]);
            k  = mpos[i];
            rs = (k != 0) && (w[NP+1] || th != mlat[i]);
            if (rs) k = 0;
            if (k == 0) mlat[i] = th;
            msync[i] = int'(rs);
            k++;
            if (k == SIZE) begin
                k = 0;
                if (th == 2) begin
                    if (can_adv(i)) advance(i);
                    else            mstall[i] = 1;
                end
            end
            mpos[i] = k;
            mhd[i]  = (mhd[i] + 1) % 16;
            mcnt[i]--;
        end
        if (vld[i]) begin
            if (mcnt[i] < cfg_depth[i]) begin
                mq[i][(mhd[i] + mcnt[i]) % 16] = bp[i];
                mcnt[i]++;
            end else begin
                movf[i] = 1;
            end
        end
    endtask

    task automatic step();
        #1;
        for (int i = 0; i < 2; i++) check_inst(i);
        for (int i = 0; i < 2; i++) model_edge(i);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NP+7:0] mk_word(input int th, input bit sof);
        logic [NP+7:0] w;
        w = (NP+8)'($urandom);
        w[NP+3:NP+2] = 2'(th);
        w[NP+1] = sof;
        return w;
    endfunction

    // Next word of a well-formed frame: sof on offset 0, thirds 0,1,2 in turn.
    task automatic gen(input int i);
        bp[i] = mk_word(gt[i], gk[i] == 0);
        gk[i]++;
        if (gk[i] == SIZE) begin
            gk[i] = 0;
            gt[i] = (gt[i] + 1) % 3;
        end
    endtask

    // Drive instance A into the stall, push words while stalled, then release.
    task automatic stall_run(input int pushes, input int hold);
        int n;
        n = 0;
        idle[0] = 1'b0;
        vld[1]  = 1'b0;
        for (int c = 0; c < 90; c++) begin
            if (n == 0 && mstall[0] == 0) begin
                wb[0] = 2'((mbuf[0] + 1) % 2);
                gen(0);
                vld[0] = 1'b1;
            end else begin
                n++;
                vld[0] = (n <= pushes);
                if (vld[0]) gen(0);
                if (n > hold) idle[0] = 1'b1;
            end
            step();
        end
        idle[0] = 1'b1;
        vld[0]  = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vld[i] = 1'b0; bp[i] = '0; idle[i] = 1'b1; wb[i] = '0;
            gk[i] = 0; gt[i] = 0;
            model_edge(i);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) step();

        // Back-to-back frames with the block matcher idle (B covers >4 frames).
        for (int c = 0; c < 100; c++) begin
            gen(0); gen(1);
            vld[0] = 1'b1; vld[1] = 1'b1;
            step();
        end
        vld[0] = 1'b0; vld[1] = 1'b0;
        repeat (3) step();

        stall_run(6, 20);
        stall_run(10, 15);

        // Reset mid-third, then 3 words and an unexpected sof.
        for (int c = 0; c < 3; c++) begin
            gen(0); gen(1);
            vld[0] = 1'b1; vld[1] = 1'b1;
            step();
        end
        rst_n = 1'b0;
        gen(0); gen(1);
        step();
        rst_n = 1'b1;
        vld[0] = 1'b0; vld[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin gk[i] = 0; gt[i] = 0; end
        step();
        for (int c = 0; c < 3; c++) begin
            gen(0); gen(1);
            vld[0] = 1'b1; vld[1] = 1'b1;
            step();
        end
        for (int i = 0; i < 2; i++) begin
            bp[i] = mk_word(gt[i], 1'b1);
            gk[i] = 1;
        end
        step();
        for (int c = 0; c < 4; c++) begin
            gen(0); gen(1);
            step();
        end

        // Random traffic, handshake and occasional corrupted sof/third fields.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                vld[i] = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 29) == 0) bp[i] = mk_word($urandom_range(0, 3), 1'($urandom_range(0, 1)));
                else if (vld[i]) gen(i);
                idle[i] = ($urandom_range(0, 3) != 0);
                wb[i]   = 2'($urandom_range(0, cfg_nb[i] - 1));
            end
            step();
        end
        for (int i = 0; i < 2; i++) begin vld[i] = 1'b0; idle[i] = 1'b1; end
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
